// File: rtl/sram_cfg_pkg.sv
// rtl/sram_cfg_pkg.sv - shared SRAM width-config constants and response type
package sram_cfg_pkg;

    localparam logic [1:0] CONF_32   = 2'b00;
    localparam logic [1:0] CONF_16   = 2'b01;
    localparam logic [1:0] CONF_8    = 2'b10;
    localparam logic [1:0] CONF_RSVD = 2'b11;

    localparam int WORD_W = 32;
    localparam int LANE_W = 8;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              err;
    } rsp_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - DEPTH-entry in-order response buffer with occupancy output
module sram_rsp_fifo
    import sram_cfg_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  rsp_t             push_data,
    input  logic             pop,
    output rsp_t             head,
    output logic [OCC_W-1:0] occ
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    rsp_t             mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_pop;

    assign do_pop = pop && (occ != '0);

    // Storage is not reset; head is forced to zero while empty so stale entries never show.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign head = (occ != '0) ? mem[rptr] : '0;

endmodule

// File: rtl/sram_rdata_align.sv
// rtl/sram_rdata_align.sv - SRAM read return path: lane extract, zero-extend, buffered response
module sram_rdata_align
    import sram_cfg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_addr,
    input  logic [1:0]        req_conf,
    output logic              sram_ren,
    input  logic [WORD_W-1:0] sram_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_err
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             acc;
    logic             inflt_v;
    logic [1:0]       inflt_addr;
    logic [1:0]       inflt_conf;
    rsp_t             push_rsp;
    rsp_t             head;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   committed;

    // Credit counts the in-flight read too, so a push can never meet a full FIFO.
    assign committed = {1'b0, occ} + {{OCC_W{1'b0}}, inflt_v};
    assign req_ready = rst_n && (committed < (OCC_W + 1)'(DEPTH));
    assign acc       = req_valid && req_ready;
    assign sram_ren  = acc && (req_conf != CONF_RSVD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflt_v    <= 1'b0;
            inflt_addr <= 2'b00;
            inflt_conf <= CONF_32;
        end else begin
            inflt_v <= acc;
            if (acc) begin
                inflt_addr <= req_addr;
                inflt_conf <= req_conf;
            end
        end
    end

    always_comb begin
        push_rsp = '0;
        case (inflt_conf)
            CONF_32: push_rsp.data = sram_rdata;
            CONF_16: begin
                if (inflt_addr[0]) begin
                    push_rsp.data = {16'h0000, sram_rdata[31:16]};
                end else begin
                    push_rsp.data = {16'h0000, sram_rdata[15:0]};
                end
            end
            CONF_8: begin
                case (inflt_addr)
                    2'd0:    push_rsp.data = {24'h000000, sram_rdata[7:0]};
                    2'd1:    push_rsp.data = {24'h000000, sram_rdata[15:8]};
                    2'd2:    push_rsp.data = {24'h000000, sram_rdata[23:16]};
                    default: push_rsp.data = {24'h000000, sram_rdata[31:24]};
                endcase
            end
            default: push_rsp.err = 1'b1;
        endcase
    end

    sram_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflt_v),
        .push_data (push_rsp),
        .pop       (rsp_valid && rsp_ready),
        .head      (head),
        .occ       (occ)
    );

    assign rsp_valid = (occ != '0);
    assign rsp_data  = head.data;
    assign rsp_err   = head.err;

endmodule
